coin_request_front: RTL
=======================

# coin_request_front

Customer-side front end for the vending core: it collects coin pulses into a credit and latches a product selection. It then presents a purchase request (money, product type, quantity) to the core over a valid/ready handshake. It sits between the coin/keypad inputs and the core's purchase port and drives that port's `customer_money`, `supply_type` and `customer_amount`. Aborted transactions are returned through a refund handshake.

## Interface
- `MAX_CREDIT`, default 99: highest credit accepted; matches the two-digit seven-segment range.
- `TIMEOUT_CYCLES`, default 1000: inactivity limit in COLLECT; used only with the timeout macro.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  one-cycle coin-insert strobe.
- `coin_value`  in  2  coin code: 00→1, 01→2, 10→5, 11→10.
- `sel_valid`  in  1  one-cycle selection strobe.
- `sel_type`  in  3  product type, 0–7.
- `sel_amount`  in  4  quantity, 1–15; 0 is invalid.
- `cancel`  in  1  one-cycle abort strobe.
- `req_ready`  in  1  core accepts the request.
- `refund_ack`  in  1  coin return accepts the refund.
- `req_valid`  out  1  purchase request valid.
- `customer_money`  out  7  credit offered with the request.
- `supply_type`  out  3  latched product type.
- `customer_amount`  out  4  latched quantity.
- `refund_valid`  out  1  refund pending.
- `refund_value`  out  7  amount to refund.
- `coin_reject`  out  1  one-cycle pulse: the coin was not credited.
- `credit`  out  7  live credit, for display.

## Operation
- FSM states: IDLE, COLLECT, REQUEST, REFUND.
- **IDLE**
  - Credit is 0.
  - An accepted coin sets credit to its value and moves to COLLECT.
  - `sel_valid` and `cancel` are ignored.
- **COLLECT**
  - Each coin adds its value to credit.
  - If credit + value > `MAX_CREDIT`, the coin is not added and `coin_reject` pulses.
  - `sel_valid` with `sel_amount` ≠ 0 latches `sel_type`/`sel_amount` and moves to REQUEST.
  - `sel_valid` with `sel_amount` = 0 is ignored.
  - `cancel` moves to REFUND.
- **REQUEST**
  - `req_valid` is 1.
  - `customer_money`, `supply_type` and `customer_amount` stay stable until the handshake.
  - `req_valid` & `req_ready` (handshake): credit clears to 0 and the FSM goes to IDLE.
  - Coins are rejected (`coin_reject` pulses).
  - `cancel` is ignored; a request is never retracted.
- **REFUND**
  - `refund_valid` is 1 and `refund_value` equals credit.
  - `refund_valid` & `refund_ack`: credit clears and the FSM goes to IDLE.
  - Coins are rejected.
- Simultaneous events in COLLECT:
  - coin + `sel_valid`: the coin is added first, and the request carries the summed credit.
  - `cancel` + `sel_valid`: cancel wins.
  - `cancel` + coin: the coin is added (if it fits), and the refund includes it.
- Arithmetic:
  - 7-bit unsigned.
  - The overflow check uses an 8-bit sum, so no wrap-around is possible.

## Timing
- All outputs are registered.
- Reset values: `req_valid`=0, `refund_valid`=0, `coin_reject`=0, `customer_money`=0, `supply_type`=0, `customer_amount`=0, `refund_value`=0, `credit`=0; state = IDLE.
- `credit` updates on the edge where `coin_valid` is sampled.
- `coin_reject` is high for exactly the cycle after the rejected coin is sampled.
- `req_valid` rises one cycle after `sel_valid` is sampled.
- Handshakes:
  - A handshake completes on any edge where valid & ready/ack are both high. `req_ready`/`refund_ack` may already be high when valid rises.
  - After the handshake edge, valid is low the next cycle.
- Minimum transaction: coin (cycle 0), selection (cycle 1), `req_valid` (cycle 2); with `req_ready` high, IDLE at cycle 3.
- Reset mid-operation: the FSM immediately returns to IDLE with all outputs at reset values. Pending credit is discarded and no refund is issued.

## Configuration
- Macro: `COIN_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to COLLECT and on every coin sampled in COLLECT.
  - Once it reaches `TIMEOUT_CYCLES` with no selection or cancel, the FSM enters REFUND.
  - The counter does not run in IDLE, REQUEST or REFUND.
- Not defined: no counter, and COLLECT waits indefinitely.

## Test plan
- Coin codes 11, 11 then selection type 3, amount 1, `req_ready` held 1 → `req_valid` for 1 cycle with `customer_money`=20, `supply_type`=3, `customer_amount`=1; then IDLE with credit 0.
- Credit 95, coin code 10 → `coin_reject` pulse, credit stays 95. Coin code 01 → credit 97.
- Credit 7, `cancel` + coin code 00 in the same cycle → `refund_value`=8. `refund_ack` low for 3 cycles: `refund_valid` stays high. Ack → IDLE.
- In REQUEST with `req_ready`=0 for 5 cycles, drive a coin and `cancel` → outputs stable, one `coin_reject` pulse, cancel has no effect. Then `req_ready`=1 completes the request.
- Selection with `sel_amount`=0 in COLLECT → no `req_valid`, credit unchanged. `rst_n` low mid-REFUND → all outputs 0 immediately.
- With `COIN_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10, insert coin code 10 and go idle → `refund_valid` with 5 after 10 idle cycles. Without the macro, still in COLLECT after 50 cycles.

Source files
------------

// File: rtl/coin_request_front.sv
// coin_request_front: collects coin pulses into a credit, latches a product
// selection and offers a purchase request to the vending core over a
// valid/ready handshake. Aborted transactions leave through a refund
// handshake. Every output is a flop.
// Optional feature: define COIN_TIMEOUT_EN to return the credit after
// TIMEOUT_CYCLES cycles of inactivity in COLLECT.
module coin_request_front #(
    parameter int unsigned MAX_CREDIT     = 99,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       sel_valid,
    input  logic [2:0] sel_type,
    input  logic [3:0] sel_amount,
    input  logic       cancel,
    input  logic       req_ready,
    input  logic       refund_ack,
    output logic       req_valid,
    output logic [6:0] customer_money,
    output logic [2:0] supply_type,
    output logic [3:0] customer_amount,
    output logic       refund_valid,
    output logic [6:0] refund_value,
    output logic       coin_reject,
    output logic [6:0] credit
);

    typedef enum logic [1:0] {IDLE, COLLECT, REQUEST, REFUND} state_t;

    state_t     state, state_n;
    logic [6:0] credit_n, money_n, refund_n;
    logic [2:0] type_n;
    logic [3:0] amount_n;
    logic       reject_n;
    logic [6:0] coin_amt;
    logic [7:0] coin_sum;
    logic       coin_fits;

`ifdef COIN_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] idle_cnt, idle_cnt_n;
`endif

    // Decode the coin code and check whether it fits under the credit ceiling.
    always_comb begin
        unique case (coin_value)
            2'b00:   coin_amt = 7'd1;
            2'b01:   coin_amt = 7'd2;
            2'b10:   coin_amt = 7'd5;
            default: coin_amt = 7'd10;
        endcase
        coin_sum  = {1'b0, credit} + {1'b0, coin_amt};
        coin_fits = (coin_sum <= 8'(MAX_CREDIT));
    end

    // Next-state and next-output logic; a coin is resolved before any
    // selection or cancel sampled in the same cycle.
    always_comb begin
        state_n  = state;
        credit_n = credit;
        money_n  = customer_money;
        type_n   = supply_type;
        amount_n = customer_amount;
        refund_n = refund_value;
        reject_n = 1'b0;
`ifdef COIN_TIMEOUT_EN
        idle_cnt_n = idle_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_n = coin_sum[6:0];
                        state_n  = COLLECT;
`ifdef COIN_TIMEOUT_EN
                        idle_cnt_n = '0;
`endif
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (coin_valid) begin
                    if (coin_fits) credit_n = coin_sum[6:0];
                    else           reject_n = 1'b1;
`ifdef COIN_TIMEOUT_EN
                    idle_cnt_n = '0;
`endif
                end
                if (cancel) begin
                    state_n  = REFUND;
                    refund_n = credit_n;
                end else if (sel_valid && sel_amount != 4'd0) begin
                    state_n  = REQUEST;
                    money_n  = credit_n;
                    type_n   = sel_type;
                    amount_n = sel_amount;
                end
`ifdef COIN_TIMEOUT_EN
                else if (!coin_valid) begin
                    if (idle_cnt == TO_LAST) begin
                        state_n  = REFUND;
                        refund_n = credit;
                    end else begin
                        idle_cnt_n = idle_cnt + 1'b1;
                    end
                end
`endif
            end
            REQUEST: begin
                reject_n = coin_valid;
                if (req_ready) begin
                    state_n  = IDLE;
                    credit_n = '0;
                    money_n  = '0;
                end
            end
            REFUND: begin
                reject_n = coin_valid;
                if (refund_ack) begin
                    state_n  = IDLE;
                    credit_n = '0;
                    refund_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; valids are decoded from the next state
    // so they rise together with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            credit          <= '0;
            customer_money  <= '0;
            supply_type     <= '0;
            customer_amount <= '0;
            refund_value    <= '0;
            coin_reject     <= 1'b0;
            req_valid       <= 1'b0;
            refund_valid    <= 1'b0;
        end else begin
            state           <= state_n;
            credit          <= credit_n;
            customer_money  <= money_n;
            supply_type     <= type_n;
            customer_amount <= amount_n;
            refund_value    <= refund_n;
            coin_reject     <= reject_n;
            req_valid       <= (state_n == REQUEST);
            refund_valid    <= (state_n == REFUND);
        end
    end

`ifdef COIN_TIMEOUT_EN
    // Inactivity counter for the COLLECT timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt <= '0;
        else        idle_cnt <= idle_cnt_n;
    end
`endif

endmodule
